paper_executor: RTL and testbench
=================================

# paper_executor

Instruction store and execute sequencer for the paper processor, sitting directly downstream of the 2-bit program counter. It consumes the counter's `select` address, fetches one of four 6-bit instructions, and executes it against four 4-bit data registers. It then drives `openpulse`/`enabled`/`jno` back into the counter to either advance it or load a jump target. It also provides program/register load ports and status for the bench and top level.

## Interface
Parameters: none. All widths are fixed: 4 instructions × 6 bits, 4 registers × 4 bits.

Ports:
- `clk`  in  1  system clock, rising edge.
- `Rn`  in  1  reset, asynchronous, active-low.
- `select`  in  2  current instruction address from the program counter.
- `start`  in  1  one-cycle request to begin or resume execution.
- `prog_we`  in  1  program write strobe.
- `prog_addr`  in  2  program write address.
- `prog_data`  in  6  instruction word: [5:4] opcode, [3:2] register index, [1:0] jump target.
- `reg_we`  in  1  data register write strobe.
- `reg_addr`  in  2  data register write/read address.
- `reg_data`  in  4  data register write value.
- `rd_data`  out  4  combinational read of register `reg_addr`.
- `openpulse`  out  1  one-cycle retire strobe to the counter.
- `enabled`  out  1  jump taken; valid only while `openpulse`=1.
- `jno`  out  2  jump target; valid only while `openpulse`=1.
- `busy`  out  1  high in FETCH/EXEC/PULSE.
- `halted`  out  1  high in HALT.
- `ovf`  out  1  sticky wrap flag.
- `retired`  out  8  count of retired non-HLT instructions.

## Operation
- Opcodes:
  - 00 INC R[r]: R[r]+1 mod 16.
  - 01 DEC R[r]: R[r]−1 mod 16.
  - 10 JNO: jump to target if R[r]≠0.
  - 11 HLT: stop.
- FSM states are IDLE, FETCH, EXEC, PULSE and HALT. Transitions:
  - IDLE: `start`=1 → FETCH.
  - FETCH: IR ← mem[`select`] → EXEC.
  - EXEC, opcode HLT: → HALT. No pulse is issued and `retired` does not change.
  - EXEC, opcode INC/DEC: write R[r] → PULSE.
  - EXEC, opcode JNO: latch taken = (R[r]≠0) → PULSE.
  - PULSE: `openpulse`=1 and `retired`+1 (wraps 255→0) → FETCH.
  - HALT: `start`=1 → FETCH. The counter is not touched, so a resumed run re-fetches the HLT unless the program was rewritten.
- Outputs during PULSE:
  - JNO taken: `enabled`=1, `jno`=IR[1:0].
  - All other cases: `enabled`=0, `jno`=00.
- Outside PULSE: `openpulse`=0, `enabled`=0, `jno`=00.
- `ovf` is set by INC 15→0 or DEC 0→15. It is cleared only by reset or by a `start` accepted in IDLE.
- `prog_we` and `reg_we` are honoured only in IDLE or HALT; they are ignored while `busy`. `start` is ignored while `busy`.
- Simultaneous `reg_we` and `start` in IDLE/HALT: the write is performed and the FSM moves to FETCH in the same edge.

## Timing
- Reset (`Rn`=0, asynchronous) produces:
  - state IDLE;
  - all registers, program words and IR = 0;
  - `openpulse`/`enabled`/`jno`/`busy`/`halted`/`ovf` = 0, `retired`=0.
- Release of reset is synchronous to `clk`. Reset asserted mid-instruction aborts it with no pulse and no partial register write.
- Each INC/DEC/JNO takes exactly 3 cycles: FETCH, EXEC, PULSE.
- The counter updates on the `clk` edge that ends PULSE. `select` must be stable by the next FETCH edge.
- `start` is accepted on edge N; FETCH occupies cycle N+1 and the first `openpulse` appears in cycle N+3.
- HLT is detected 2 cycles after its FETCH begins; `halted` rises on that edge.
- `rd_data` reflects a register write on the cycle after the writing edge.

## Test plan
The bench pairs the block with the team's 2-bit program counter or a cycle-accurate behavioural model of it.

- **Reset:** reset pulse mid-EXEC → all outputs 0, state IDLE, R0..R3 = 0, no `openpulse` in the following 5 cycles.
- **Countdown loop:**
  - Setup: mem0=6'h10 (DEC R0), mem1=6'h20 (JNO R0→0), mem2=6'h30 (HLT); R0=3; `start`.
  - Expected `openpulse` sequence `enabled`/`jno`: 0/00, 1/00, 0/00, 1/00, 0/00, 0/00.
  - Then `halted`=1, R0=0, `retired`=6, `ovf`=0.
- **Wrap:**
  - Setup: mem0=6'h04 (INC R1), mem1=6'h30; R1=15; `start`.
  - Expected: R1=0, `ovf`=1, `retired`=1, `halted`=1.
  - A following `start` from IDLE after reset clears `ovf`.
- **DEC underflow:** R2=0, DEC R2 → R2=15, `ovf`=1.
- **Write lockout:** `prog_we` and `reg_we` pulsed while `busy`=1 → memory and registers unchanged. The same writes in HALT take effect and `rd_data` shows the new value the next cycle.
- **Start while busy:** pulse `start` during PULSE → no extra instruction, cycle count per instruction stays 3, `retired` increments by exactly 1.

Source files
------------

// File: rtl/paper_executor.sv
// paper_executor: 4-word instruction store plus INC/DEC/JNO/HLT sequencer driving the paper program counter.
// Latency: start accepted on edge N, FETCH in N+1, retire strobe in N+3; each non-HLT instruction takes 3 cycles.
// Backpressure: none; start and program/register writes are ignored while busy, the counter advances only on openpulse.
module paper_executor (
  input  logic       clk,
  input  logic       Rn,
  input  logic [1:0] select,
  input  logic       start,
  input  logic       prog_we,
  input  logic [1:0] prog_addr,
  input  logic [5:0] prog_data,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [3:0] reg_data,
  output logic [3:0] rd_data,
  output logic       openpulse,
  output logic       enabled,
  output logic [1:0] jno,
  output logic       busy,
  output logic       halted,
  output logic       ovf,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_PULSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_DEC = 2'b01;
  localparam logic [1:0] OP_JNO = 2'b10;
  localparam logic [1:0] OP_HLT = 2'b11;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_mem [4];
  logic [3:0] r_reg [4];
  logic [5:0] r_ir;
  logic       r_taken;
  logic       r_ovf;
  logic [7:0] r_retired;

  logic       w_wr_ok;
  logic [1:0] w_op;
  logic [1:0] w_ri;
  logic [3:0] w_cur;

  // Host writes are only safe when the sequencer is parked.
  assign w_wr_ok = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_op    = r_ir[5:4];
  assign w_ri    = r_ir[3:2];
  assign w_cur   = r_reg[w_ri];
  assign rd_data = r_reg[reg_addr];
  assign ovf     = r_ovf;
  assign retired = r_retired;

  // State register.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs; the jump fields are forced to zero outside PULSE.
  always_comb begin
    w_next    = r_state;
    openpulse = 1'b0;
    enabled   = 1'b0;
    jno       = 2'b00;
    busy      = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        busy   = 1'b1;
        w_next = (w_op == OP_HLT) ? S_HALT : S_PULSE;
      end
      S_PULSE: begin
        busy      = 1'b1;
        openpulse = 1'b1;
        enabled   = r_taken;
        jno       = r_taken ? r_ir[1:0] : 2'b00;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Instruction store: loaded only while parked.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 6'd0;
    end else if (w_wr_ok && prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Data registers and wrap flag: host writes when parked, INC/DEC writeback in EXEC.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      for (int i = 0; i < 4; i++) r_reg[i] <= 4'd0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr_ok && reg_we) r_reg[reg_addr] <= reg_data;
      if ((r_state == S_IDLE) && start) r_ovf <= 1'b0;
      if (r_state == S_EXEC) begin
        if (w_op == OP_INC) begin
          r_reg[w_ri] <= w_cur + 4'd1;
          if (w_cur == 4'hF) r_ovf <= 1'b1;
        end else if (w_op == OP_DEC) begin
          r_reg[w_ri] <= w_cur - 4'd1;
          if (w_cur == 4'h0) r_ovf <= 1'b1;
        end
      end
    end
  end

  // Instruction register, jump decision and retire counter.
  always_ff @(posedge clk or negedge Rn) begin
    if (!Rn) begin
      r_ir      <= 6'd0;
      r_taken   <= 1'b0;
      r_retired <= 8'd0;
    end else begin
      if (r_state == S_FETCH) r_ir <= r_mem[select];
      if (r_state == S_EXEC) r_taken <= (w_op == OP_JNO) && (w_cur != 4'd0);
      if (r_state == S_PULSE) r_retired <= r_retired + 8'd1;
    end
  end

endmodule

// File: tb/tb_paper_executor.sv
// Bench for paper_executor: pairs the block with a behavioural 2-bit program counter,
// runs a table of programs, randomized programs against a program-level reference model,
// and hand-written sequences for reset abort, write lockout, HALT resume and start-while-busy.
module tb_paper_executor;

  logic       clk;
  logic       Rn;
  logic [1:0] sel;
  logic       start;
  logic       prog_we;
  logic [1:0] prog_addr;
  logic [5:0] prog_data;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [3:0] reg_data;
  logic [3:0] rd_data;
  logic       openpulse;
  logic       enabled;
  logic [1:0] jno;
  logic       busy;
  logic       halted;
  logic       ovf;
  logic [7:0] retired;

  int checks = 0;
  int errors = 0;

  paper_executor dut (
    .clk(clk), .Rn(Rn), .select(sel), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .rd_data(rd_data), .openpulse(openpulse), .enabled(enabled), .jno(jno),
    .busy(busy), .halted(halted), .ovf(ovf), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter: advance on a retire strobe, load the target when the jump is taken.
  always @(posedge clk or negedge Rn) begin
    if (!Rn) sel <= 2'b00;
    else if (openpulse) sel <= enabled ? jno : sel + 2'd1;
  end

  // Reference model state (program level, not cycle level).
  logic [5:0] m_prog [4];
  logic [3:0] m_regs [4];
  logic [2:0] m_pulses [$];
  int         m_pc0;
  int         m_ret;
  bit         m_ovf;
  bit         m_halt;

  typedef struct {
    logic [23:0] prog;
    logic [15:0] regs;
    logic [15:0] exp_regs;
    int          exp_ret;
    bit          exp_ovf;
    bit          exp_halt;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    Rn = 1'b0;
    @(posedge clk);
    #1;
    Rn = 1'b1;
  endtask

  // Execute the program instruction by instruction until HLT or the step limit.
  task automatic model_run(input int limit);
    int pc;
    int steps;
    int op;
    int r;
    int v;
    pc = m_pc0;
    steps = 0;
    m_pulses.delete();
    m_halt = 0;
    while (steps < limit) begin
      op = int'(m_prog[pc][5:4]);
      r  = int'(m_prog[pc][3:2]);
      v  = int'(m_regs[r]);
      if (op == 3) begin
        m_halt = 1;
        break;
      end
      if (op == 0) begin
        if (v == 15) m_ovf = 1;
        m_regs[r] = 4'((v + 1) % 16);
        m_pulses.push_back(3'b000);
        pc = (pc + 1) % 4;
      end else if (op == 1) begin
        if (v == 0) m_ovf = 1;
        m_regs[r] = 4'((v + 15) % 16);
        m_pulses.push_back(3'b000);
        pc = (pc + 1) % 4;
      end else begin
        if (v != 0) begin
          m_pulses.push_back({1'b1, m_prog[pc][1:0]});
          pc = int'(m_prog[pc][1:0]);
        end else begin
          m_pulses.push_back(3'b000);
          pc = (pc + 1) % 4;
        end
      end
      m_ret = (m_ret + 1) % 256;
      steps++;
    end
  endtask

  // Watch retire strobes against the model until HLT, or stop after `limit` strobes.
  task automatic observe(input int limit);
    int seen;
    int cyc;
    bit done;
    seen = 0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 4 * limit + 20) begin
      @(negedge clk);
      cyc++;
      if (openpulse) begin
        if (seen < m_pulses.size()) begin
          chk("pulse_enabled", int'(enabled), int'(m_pulses[seen][2]));
          chk("pulse_jno", int'(jno), int'(m_pulses[seen][1:0]));
        end else begin
          checks++;
          errors++;
          $display("FAIL extra_pulse actual=%0d expected=%0d", seen + 1, m_pulses.size());
        end
        seen++;
        if (!m_halt && seen == limit) begin
          @(posedge clk);
          #1;
          done = 1;
        end
      end else if (halted) begin
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout actual=%0d expected=%0d", cyc, 4 * limit + 20);
    end
    chk("pulse_count", seen, m_pulses.size());
  endtask

  task automatic check_final(input logic [15:0] exp_regs, input int exp_ret,
                             input bit exp_ovf, input bit exp_halt);
    for (int i = 0; i < 4; i++) begin
      reg_addr = 2'(i);
      #1;
      chk($sformatf("R%0d", i), int'(rd_data), int'(exp_regs[4*i +: 4]));
    end
    chk("retired", int'(retired), exp_ret);
    chk("ovf", int'(ovf), int'(exp_ovf));
    chk("halted", int'(halted), int'(exp_halt));
  endtask

  task automatic check_zero();
    chk("rst_openpulse", int'(openpulse), 0);
    chk("rst_enabled", int'(enabled), 0);
    chk("rst_jno", int'(jno), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_retired", int'(retired), 0);
    for (int i = 0; i < 4; i++) begin
      reg_addr = 2'(i);
      #1;
      chk($sformatf("rst_R%0d", i), int'(rd_data), 0);
    end
  endtask

  // Reset, load program and registers through the host ports, and mirror them into the model.
  task automatic load(input logic [23:0] prog, input logic [15:0] regs);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      prog_we   = 1'b1;
      prog_addr = 2'(i);
      prog_data = prog[6*i +: 6];
      reg_we    = 1'b1;
      reg_addr  = 2'(i);
      reg_data  = regs[4*i +: 4];
      tick();
      m_prog[i] = prog[6*i +: 6];
      m_regs[i] = regs[4*i +: 4];
    end
    prog_we = 1'b0;
    reg_we  = 1'b0;
    m_pc0 = 0;
    m_ret = 0;
    m_ovf = 0;
  endtask

  task automatic go(input int limit);
    model_run(limit);
    start = 1'b1;
    tick();
    start = 1'b0;
    observe(limit);
  endtask

  vec_t vecs [6];

  initial begin
    logic [23:0] rp;
    logic [15:0] rr;
    int          cyc;
    int          last;
    int          np;

    Rn = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 2'd0; prog_data = 6'd0;
    reg_we = 1'b0; reg_addr = 2'd0; reg_data = 4'd0;

    // Power-on reset.
    #1 Rn = 1'b0;
    #1 check_zero();
    @(posedge clk);
    #1 Rn = 1'b1;

    vecs[0] = '{{6'h00, 6'h30, 6'h20, 6'h10}, 16'h0003, 16'h0000, 6, 1'b0, 1'b1}; // countdown
    vecs[1] = '{{6'h00, 6'h00, 6'h30, 6'h04}, 16'h00F0, 16'h0000, 1, 1'b1, 1'b1}; // INC wrap
    vecs[2] = '{{6'h00, 6'h00, 6'h30, 6'h18}, 16'h0000, 16'h0F00, 1, 1'b1, 1'b1}; // DEC underflow
    vecs[3] = '{{6'h00, 6'h30, 6'h0C, 6'h0C}, 16'h5000, 16'h7000, 2, 1'b0, 1'b1}; // INC R3 twice
    vecs[4] = '{{6'h00, 6'h00, 6'h30, 6'h27}, 16'h0000, 16'h0000, 1, 1'b0, 1'b1}; // JNO not taken
    vecs[5] = '{{6'h00, 6'h30, 6'h00, 6'h26}, 16'h0010, 16'h0010, 1, 1'b0, 1'b1}; // JNO taken over INC

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].prog, vecs[v].regs);
      go(40);
      check_final(vecs[v].exp_regs, vecs[v].exp_ret, vecs[v].exp_ovf, vecs[v].exp_halt);
    end

    // Randomized programs against the reference model.
    for (int t = 0; t < 20; t++) begin
      rp = 24'($urandom());
      rr = 16'($urandom());
      load(rp, rr);
      go(24);
      check_final({m_regs[3], m_regs[2], m_regs[1], m_regs[0]}, m_ret, m_ovf, m_halt);
    end

    // Reset asserted during EXEC aborts the instruction and clears everything.
    load({6'h00, 6'h30, 6'h20, 6'h10}, 16'h0003);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("busy_in_exec", int'(busy), 1);
    #2 Rn = 1'b0;
    #1 check_zero();
    @(posedge clk);
    #1 Rn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_openpulse", int'(openpulse), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
    // Cleared program memory decodes as INC R0 everywhere.
    for (int i = 0; i < 4; i++) begin
      m_prog[i] = 6'h00;
      m_regs[i] = 4'h0;
    end
    m_pc0 = 0; m_ret = 0; m_ovf = 0;
    go(2);
    check_final(16'h0002, 2, 1'b0, 1'b0);

    // Writes while busy are ignored; writes in HALT land and a resumed run uses them.
    load({6'h00, 6'h30, 6'h20, 6'h10}, 16'h0003);
    model_run(40);
    start = 1'b1;
    tick();
    start = 1'b0;
    fork
      observe(40);
      begin
        prog_we = 1'b1; prog_addr = 2'd2; prog_data = 6'h00;
        reg_we  = 1'b1; reg_addr  = 2'd0; reg_data  = 4'h9;
        repeat (6) tick();
        prog_we = 1'b0;
        reg_we  = 1'b0;
      end
    join
    check_final(16'h0000, 6, 1'b0, 1'b1);
    reg_we = 1'b1; reg_addr = 2'd1; reg_data = 4'hA;
    #1 chk("halt_wr_before_edge", int'(rd_data), 0);
    tick();
    reg_we = 1'b0;
    chk("halt_wr_after_edge", int'(rd_data), 10);
    prog_we = 1'b1; prog_addr = 2'd2; prog_data = 6'h04;
    tick();
    prog_addr = 2'd3; prog_data = 6'h30;
    tick();
    prog_we = 1'b0;
    m_prog[2] = 6'h04;
    m_prog[3] = 6'h30;
    m_regs[0] = 4'h0; m_regs[1] = 4'hA; m_regs[2] = 4'h0; m_regs[3] = 4'h0;
    m_pc0 = 2; m_ret = 6; m_ovf = 0;
    go(8);
    check_final(16'h00B0, 7, 1'b0, 1'b1);

    // start pulsed during PULSE must not disturb the 3-cycle cadence.
    load({6'h30, 6'h00, 6'h00, 6'h00}, 16'h0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; last = -1; np = 0;
    while (!halted && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (openpulse) begin
        if (last >= 0) chk("pulse_gap", cyc - last, 3);
        last = cyc;
        np++;
        if (np == 1) begin
          start = 1'b1;
          @(posedge clk);
          #1;
          start = 1'b0;
          chk("retired_after_first", int'(retired), 1);
        end
      end
    end
    chk("pulses_seen", np, 3);
    check_final(16'h0003, 3, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
